// File: rtl/frame_rect_writer.sv
// Rectangle rasteriser: erases a rectangle's old position, then paints the new one, one pixel per clock.
// Optional erase phase is compiled in with `define RECT_WR_ERASE_EN.
module frame_rect_writer #(
  parameter int SCREEN_X = 176,
  parameter int SCREEN_Y = 120,
  parameter int AW = 15,
  parameter int DW = 3,
  parameter logic [DW-1:0] BG_COLOR = 3'b000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [7:0]    old_x,
  input  logic [6:0]    old_y,
  input  logic [7:0]    new_x,
  input  logic [6:0]    new_y,
  input  logic [7:0]    rect_w,
  input  logic [6:0]    rect_h,
  input  logic [DW-1:0] color,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] mem_px_addr,
  output logic [DW-1:0] mem_px_data,
  output logic          px_wr
);

`ifdef RECT_WR_ERASE_EN
  typedef enum logic [1:0] {IDLE = 2'd0, ERASE = 2'd1, DRAW = 2'd2, DONE = 2'd3} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, DRAW = 2'd2, DONE = 2'd3} state_t;
`endif

  state_t        state_r;
  logic [7:0]    cx_r, w_r, nx_r;
  logic [6:0]    cy_r, h_r, ny_r;
  logic [DW-1:0] color_r;
  logic          busy_r, done_r, px_wr_r;
  logic [AW-1:0] addr_r;
  logic [DW-1:0] data_r;
`ifdef RECT_WR_ERASE_EN
  logic [7:0]    ox_r;
  logic [6:0]    oy_r;
`else
  logic          unused_s;
  assign unused_s = ^{old_x, old_y};
`endif

  logic [7:0]    base_x_s, cx_nxt_s;
  logic [6:0]    base_y_s, cy_nxt_s;
  logic [DW-1:0] px_data_s;
  logic [8:0]    x_s;
  logic [7:0]    y_s;
  logic          in_bounds_s, last_col_s, last_px_s;
  logic [AW-1:0] addr_s;

  // Select the scan origin and colour of the active phase.
  always_comb begin
    base_x_s  = nx_r;
    base_y_s  = ny_r;
    px_data_s = color_r;
`ifdef RECT_WR_ERASE_EN
    if (state_r == ERASE) begin
      base_x_s  = ox_r;
      base_y_s  = oy_r;
      px_data_s = BG_COLOR;
    end else begin
      base_x_s  = nx_r;
      base_y_s  = ny_r;
      px_data_s = color_r;
    end
`endif
  end

  // Pixel coordinate, clip test, address and raster-order counter advance.
  always_comb begin
    x_s         = {1'b0, base_x_s} + {1'b0, cx_r};
    y_s         = {1'b0, base_y_s} + {1'b0, cy_r};
    in_bounds_s = (x_s < 9'(SCREEN_X)) && (y_s < 8'(SCREEN_Y));
    addr_s      = AW'(y_s) * AW'(SCREEN_X) + AW'(x_s);
    last_col_s  = (cx_r == w_r - 8'd1);
    last_px_s   = last_col_s && (cy_r == h_r - 7'd1);
    if (last_col_s) begin
      cx_nxt_s = 8'd0;
      cy_nxt_s = cy_r + 7'd1;
    end else begin
      cx_nxt_s = cx_r + 8'd1;
      cy_nxt_s = cy_r;
    end
  end

  // Request FSM with registered pixel-write and status outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
      cx_r    <= 8'd0;
      cy_r    <= 7'd0;
      w_r     <= 8'd0;
      h_r     <= 7'd0;
      nx_r    <= 8'd0;
      ny_r    <= 7'd0;
      color_r <= '0;
`ifdef RECT_WR_ERASE_EN
      ox_r    <= 8'd0;
      oy_r    <= 7'd0;
`endif
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      px_wr_r <= 1'b0;
      addr_r  <= '0;
      data_r  <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          px_wr_r <= 1'b0;
          done_r  <= 1'b0;
          // The done cycle itself is not an accept window.
          if (start && !done_r) begin
            nx_r    <= new_x;
            ny_r    <= new_y;
            w_r     <= rect_w;
            h_r     <= rect_h;
            color_r <= color;
`ifdef RECT_WR_ERASE_EN
            ox_r    <= old_x;
            oy_r    <= old_y;
`endif
            cx_r    <= 8'd0;
            cy_r    <= 7'd0;
            busy_r  <= 1'b1;
            if (rect_w == 8'd0 || rect_h == 7'd0) begin
              state_r <= DONE;
            end else begin
`ifdef RECT_WR_ERASE_EN
              state_r <= ERASE;
`else
              state_r <= DRAW;
`endif
            end
          end else begin
            busy_r <= 1'b0;
          end
        end
`ifdef RECT_WR_ERASE_EN
        ERASE: begin
          px_wr_r <= in_bounds_s;
          addr_r  <= addr_s;
          data_r  <= px_data_s;
          if (last_px_s) begin
            cx_r    <= 8'd0;
            cy_r    <= 7'd0;
            state_r <= DRAW;
          end else begin
            cx_r <= cx_nxt_s;
            cy_r <= cy_nxt_s;
          end
        end
`endif
        DRAW: begin
          px_wr_r <= in_bounds_s;
          addr_r  <= addr_s;
          data_r  <= px_data_s;
          if (last_px_s) begin
            state_r <= DONE;
          end else begin
            cx_r <= cx_nxt_s;
            cy_r <= cy_nxt_s;
          end
        end
        DONE: begin
          px_wr_r <= 1'b0;
          busy_r  <= 1'b0;
          done_r  <= 1'b1;
          state_r <= IDLE;
        end
        default: begin
          px_wr_r <= 1'b0;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign busy        = busy_r;
  assign done        = done_r;
  assign px_wr       = px_wr_r;
  assign mem_px_addr = addr_r;
  assign mem_px_data = data_r;

endmodule

// File: tb/tb_frame_rect_writer.sv
// Scoreboard bench for frame_rect_writer: a raster model queues expected writes and done cycles,
// a negedge monitor pops and compares them. Follows `RECT_WR_ERASE_EN like the design.
module tb_frame_rect_writer;
  logic        clk = 1'b0, rst = 1'b0, start = 1'b0;
  logic [7:0]  old_x = 8'd0, new_x = 8'd0, rect_w = 8'd0;
  logic [6:0]  old_y = 7'd0, new_y = 7'd0, rect_h = 7'd0;
  logic [2:0]  color = 3'b000;
  logic        busy, done, px_wr;
  logic [14:0] mem_px_addr;
  logic [2:0]  mem_px_data;

  frame_rect_writer dut (
    .clk(clk), .rst(rst), .start(start),
    .old_x(old_x), .old_y(old_y), .new_x(new_x), .new_y(new_y),
    .rect_w(rect_w), .rect_h(rect_h), .color(color),
    .busy(busy), .done(done), .mem_px_addr(mem_px_addr),
    .mem_px_data(mem_px_data), .px_wr(px_wr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int cyc; int addr; int data; } wr_t;
  wr_t exp_q[$];
  int  done_q[$];
  int  checks = 0, failures = 0;
  wr_t e;

  // Monitor: every write and done pulse must match the head of its queue.
  always @(negedge clk) begin
    if (rst) begin
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        e = exp_q.pop_front();
        checks++; failures++;
        $display("FAIL missed_write cyc=%0d addr=%0d data=%0d not seen", e.cyc, e.addr, e.data);
      end
      while (done_q.size() > 0 && done_q[0] < cyc) begin
        checks++; failures++;
        $display("FAIL missed_done expected at cyc=%0d not seen", done_q.pop_front());
      end
      if (px_wr) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_write cyc=%0d addr=%0d data=%0d, required no write", cyc, mem_px_addr, mem_px_data);
        end else begin
          e = exp_q.pop_front();
          if (e.cyc != cyc || e.addr != int'(mem_px_addr) || e.data != int'(mem_px_data)) begin
            failures++;
            $display("FAIL write got cyc=%0d addr=%0d data=%0d, required cyc=%0d addr=%0d data=%0d",
                     cyc, mem_px_addr, mem_px_data, e.cyc, e.addr, e.data);
          end
        end
      end
      if (done) begin
        checks++;
        if (done_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_done cyc=%0d, required no done", cyc);
        end else if (done_q[0] != cyc || busy !== 1'b0) begin
          failures++;
          $display("FAIL done got cyc=%0d busy=%0b, required cyc=%0d busy=0", cyc, busy, done_q[0]);
          void'(done_q.pop_front());
        end else begin
          void'(done_q.pop_front());
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s got=%0d required=%0d", name, act, req);
    end
  endtask

  // Reference: raster scan of one phase; every pixel takes a cycle, only on-screen ones write.
  task automatic model_phase(input int n, inout int k, input int bx, input int by,
                             input int w, input int h, input int col);
    for (int y = 0; y < h; y++) begin
      for (int x = 0; x < w; x++) begin
        if (bx + x < 176 && by + y < 120)
          exp_q.push_back('{n + 2 + k, (by + y) * 176 + (bx + x), col});
        k++;
      end
    end
  endtask

  task automatic wait_done(input int bound);
    int t = 0;
    while (done_q.size() != 0 && t < bound) begin
      @(posedge clk); #1;
      t++;
    end
    if (done_q.size() != 0) begin
      checks++; failures++;
      $display("FAIL timeout waiting for done after %0d cycles", bound);
      done_q.delete();
      exp_q.delete();
    end
  endtask

  // Issue one request at the current cycle; optionally a spurious start at N+3 or a reset at N+abort.
  task automatic issue(input logic [7:0] ox, input logic [6:0] oy, input logic [7:0] nx,
                       input logic [6:0] ny, input logic [7:0] w, input logic [6:0] h,
                       input logic [2:0] c, input bit dup, input int abort);
    int n, k;
    n = cyc; k = 0;
    old_x = ox; old_y = oy; new_x = nx; new_y = ny; rect_w = w; rect_h = h; color = c;
    start = 1'b1;
`ifdef RECT_WR_ERASE_EN
    model_phase(n, k, int'(ox), int'(oy), int'(w), int'(h), 0);
`endif
    model_phase(n, k, int'(nx), int'(ny), int'(w), int'(h), int'(c));
    done_q.push_back(n + 2 + k);
    @(posedge clk); #1;
    start = 1'b0;
    old_x = 8'($urandom); old_y = 7'($urandom); new_x = 8'($urandom); new_y = 7'($urandom);
    rect_w = 8'($urandom); rect_h = 7'($urandom); color = 3'($urandom);
    chk("busy_after_start", int'(busy), 1);
    if (dup) begin
      @(posedge clk); #1;
      @(posedge clk); #1;
      new_x = 8'd50; new_y = 7'd50; rect_w = 8'd3; rect_h = 7'd1; color = 3'b111;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
    end
    if (abort > 0) begin
      repeat (abort - 1) begin @(posedge clk); #1; end
      rst = 1'b0;
      exp_q.delete();
      done_q.delete();
      #1;
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_px_wr", int'(px_wr), 0);
      @(posedge clk); #1;
      rst = 1'b1;
      repeat (20) begin @(posedge clk); #1; end
    end else begin
      wait_done(2 * int'(w) * int'(h) + 20);
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_px_wr", int'(px_wr), 0);
    chk("reset_addr", int'(mem_px_addr), 0);
    chk("reset_data", int'(mem_px_data), 0);
    rst = 1'b1;
    @(posedge clk); #1;

    issue(8'd0, 7'd0, 8'd10, 7'd5, 8'd2, 7'd2, 3'b100, 1'b0, 0);     // basic
    issue(8'd0, 7'd0, 8'd174, 7'd119, 8'd4, 7'd2, 3'b011, 1'b0, 0);  // clipped corner
    issue(8'd5, 7'd5, 8'd5, 7'd5, 8'd0, 7'd3, 3'b101, 1'b0, 0);      // zero width
    issue(8'd5, 7'd5, 8'd5, 7'd5, 8'd3, 7'd0, 3'b101, 1'b0, 0);      // zero height
    issue(8'd0, 7'd0, 8'd10, 7'd5, 8'd2, 7'd2, 3'b100, 1'b1, 0);     // start while busy
    repeat (10) begin @(posedge clk); #1; end
    issue(8'd0, 7'd0, 8'd10, 7'd5, 8'd2, 7'd2, 3'b100, 1'b0, 4);     // reset mid-request
    issue(8'd0, 7'd0, 8'd10, 7'd5, 8'd2, 7'd2, 3'b100, 1'b0, 0);     // full rerun
    issue(8'd170, 7'd116, 8'd3, 7'd7, 8'd3, 7'd2, 3'b010, 1'b0, 0);  // back-to-back after done

    for (int i = 0; i < 25; i++) begin
      logic [7:0] rx, rw;
      logic [6:0] ry, rh;
      rx = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(165, 180));
      ry = ($urandom_range(0, 1) == 0) ? 7'($urandom_range(0, 127)) : 7'($urandom_range(112, 124));
      rw = 8'($urandom_range(0, 10));
      rh = 7'($urandom_range(0, 6));
      issue(8'($urandom_range(0, 255)), 7'($urandom_range(0, 127)), rx, ry, rw, rh,
            3'($urandom), 1'b0, 0);
    end

    repeat (10) begin @(posedge clk); #1; end
    chk("writes_left", exp_q.size(), 0);
    chk("dones_left", done_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
